// File: rtl/i2c_pkg.sv
// ---------------------------------------------------------------------------
// i2c_pkg
// Shared definitions for the I2C master:
//   i2c_state_e : controller states (IDLE, START, DATA, ACK, HOLD, STOP)
//   Q0..Q3      : quarter-phase indices inside one SCL bit period
// ---------------------------------------------------------------------------
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_ACK   = 3'd3,
        ST_HOLD  = 3'd4,
        ST_STOP  = 3'd5
    } i2c_state_e;

    // A bit period is four quarters: SCL low in Q0/Q3, high in Q1/Q2.
    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

endpackage

// File: rtl/i2c_qtick_gen.sv
// ---------------------------------------------------------------------------
// i2c_qtick_gen
// Quarter-period tick generator. tick is high on the last clk cycle of every
// QDIV-cycle quarter. clear restarts the count so the next quarter is a full
// QDIV cycles long.
// Ports:
//   clk   : system clock
//   reset : asynchronous, active-high
//   clear : restart the quarter count (driven on FSM state entry)
//   tick  : one-cycle pulse at the end of each quarter
// ---------------------------------------------------------------------------
module i2c_qtick_gen #(
    parameter int QDIV = 250
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CW = (QDIV > 1) ? $clog2(QDIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(QDIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clear || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/i2c_master.sv
// ---------------------------------------------------------------------------
// i2c_master
// Single-master, write-only I2C byte engine. One command sends either a
// START (or repeated START) plus one byte, a plain byte, or a STOP.
// Ports:
//   clk, reset : system clock; asynchronous active-high reset
//   i2c_en     : command valid
//   start/stop : command qualifiers (start > stop > plain write)
//   tx_data    : byte to send, MSB first
//   ready      : command can be accepted (IDLE or HOLD)
//   tx_done    : one-cycle pulse after each byte's ACK bit
//   ack_err    : sticky NACK flag, cleared when a start command is accepted
//   scl        : push-pull I2C clock
//   sda        : open-drain I2C data (drives 0 or releases)
//   state_dbg  : current FSM state encoding
//
// Handshake: a command transfers on a posedge where i2c_en && ready. ready is
// a pure function of the state, so it drops the cycle after acceptance and
// i2c_en may be held high without causing a second transfer.
// ---------------------------------------------------------------------------
module i2c_master
    import i2c_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int I2C_FREQ = 100_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i2c_en,
    input  logic       start,
    input  logic       stop,
    input  logic [7:0] tx_data,
    output logic       ready,
    output logic       tx_done,
    output logic       ack_err,
    output logic       scl,
    inout  wire        sda,
    output logic [2:0] state_dbg
);

    localparam int QDIV = CLK_FREQ / (4 * I2C_FREQ);

    i2c_state_e  state_q, state_d;
    logic [1:0]  qcnt_q, qcnt_d;
    logic        pre_q, pre_d;       // extra released-SDA quarter of a repeated START
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        load_q, load_d;     // plain write: capture tx_data next cycle
    logic        ack_err_q, ack_err_d;
    logic        tx_done_q, tx_done_d;

    logic        tick;
    logic        clear;
    logic        accept;
    logic        sda_oe;

    assign ready     = (state_q == ST_IDLE) || (state_q == ST_HOLD);
    assign accept    = ready && i2c_en;
    assign clear     = (state_d != state_q);
    assign tx_done   = tx_done_q;
    assign ack_err   = ack_err_q;
    assign state_dbg = state_q;
    assign sda       = sda_oe ? 1'b0 : 1'bz;

    i2c_qtick_gen #(
        .QDIV (QDIV)
    ) u_qtick (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .tick  (tick)
    );

    always_comb begin
        state_d   = state_q;
        qcnt_d    = qcnt_q;
        pre_d     = pre_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        load_d    = 1'b0;
        ack_err_d = ack_err_q;
        tx_done_d = 1'b0;

        if (load_q) begin
            shift_d = tx_data;
        end

        case (state_q)
            ST_IDLE: begin
                // Without an owned bus only a start command means anything.
                if (accept && start) begin
                    state_d   = ST_START;
                    pre_d     = 1'b0;
                    ack_err_d = 1'b0;
                end
            end
            ST_HOLD: begin
                if (accept) begin
                    if (start) begin
                        state_d   = ST_START;
                        pre_d     = 1'b1;
                        ack_err_d = 1'b0;
                    end else if (stop) begin
                        state_d = ST_STOP;
                    end else begin
                        state_d = ST_DATA;
                        load_d  = 1'b1;
                    end
                end
            end
            ST_START: begin
                if (tick) begin
                    if (pre_q) begin
                        pre_d = 1'b0;
                    end else if (qcnt_q == Q3) begin
                        state_d = ST_DATA;
                        shift_d = tx_data;
                    end else begin
                        qcnt_d = qcnt_q + 2'd1;
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    qcnt_d = qcnt_q + 2'd1;  // wraps Q3 -> Q0 between bits
                    if (qcnt_q == Q3) begin
                        if (bit_cnt_q == 3'd7) begin
                            state_d = ST_ACK;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                            shift_d   = {shift_q[6:0], 1'b0};
                        end
                    end
                end
            end
            ST_ACK: begin
                if (tick) begin
                    // This tick's edge is the one where Q2 begins.
                    if (qcnt_q == Q1) begin
                        ack_err_d = ack_err_q | sda;
                    end
                    if (qcnt_q == Q3) begin
                        state_d   = ST_HOLD;
                        tx_done_d = 1'b1;
                    end else begin
                        qcnt_d = qcnt_q + 2'd1;
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (qcnt_q == Q3) begin
                        state_d = ST_IDLE;
                    end else begin
                        qcnt_d = qcnt_q + 2'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Every state entry starts at Q0 / bit 0 so state timing is exact.
        if (state_d != state_q) begin
            qcnt_d    = Q0;
            bit_cnt_d = 3'd0;
        end
    end

    // Bus levels are decoded from registered state only.
    always_comb begin
        scl    = 1'b1;
        sda_oe = 1'b0;
        case (state_q)
            ST_IDLE: begin
                scl    = 1'b1;
                sda_oe = 1'b0;
            end
            ST_HOLD: begin
                scl    = 1'b0;
                sda_oe = 1'b1;
            end
            ST_START: begin
                if (pre_q) begin
                    scl    = 1'b0;
                    sda_oe = 1'b0;
                end else begin
                    scl    = (qcnt_q == Q0) || (qcnt_q == Q1);
                    sda_oe = (qcnt_q != Q0);
                end
            end
            ST_DATA: begin
                scl    = (qcnt_q == Q1) || (qcnt_q == Q2);
                // During the capture cycle of a plain write, show the new MSB.
                sda_oe = load_q ? ~tx_data[7] : ~shift_q[7];
            end
            ST_ACK: begin
                scl    = (qcnt_q == Q1) || (qcnt_q == Q2);
                sda_oe = 1'b0;
            end
            ST_STOP: begin
                scl    = (qcnt_q != Q0);
                sda_oe = (qcnt_q == Q0) || (qcnt_q == Q1);
            end
            default: begin
                scl    = 1'b1;
                sda_oe = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            qcnt_q    <= Q0;
            pre_q     <= 1'b0;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'h00;
            load_q    <= 1'b0;
            ack_err_q <= 1'b0;
            tx_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            qcnt_q    <= qcnt_d;
            pre_q     <= pre_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            load_q    <= load_d;
            ack_err_q <= ack_err_d;
            tx_done_q <= tx_done_d;
        end
    end

endmodule

// File: doc/i2c_master.md
I2C_MASTER -- requirements
Module: i2c_master

Interface
REQ-001 Parameter CLK_FREQ, default 100_000_000, system clock frequency in Hz.
REQ-002 Parameter I2C_FREQ, default 100_000, SCL frequency in Hz; integer QDIV = CLK_FREQ/(4*I2C_FREQ), 250 at defaults.
REQ-003 clk  input  1  system clock; all logic on posedge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 i2c_en  input  1  command valid.
REQ-006 start  input  1  command qualifier: START, or repeated START, then send one byte.
REQ-007 stop  input  1  command qualifier: STOP condition.
REQ-008 tx_data  input  8  byte to transmit, MSB first.
REQ-009 ready  output  1  high when a command can be accepted.
REQ-010 tx_done  output  1  one-cycle pulse at the end of each byte's ACK bit.
REQ-011 ack_err  output  1  sticky: slave NACKed a byte.
REQ-012 scl  output  1  I2C clock, push-pull; no clock stretching.
REQ-013 sda  inout  1  I2C data, open-drain: drives 0 or releases to 'z'.

Function
REQ-014 Timing: tick every QDIV clk cycles; each bit is 4 quarters Q0-Q3; scl low in Q0 and Q3, high in Q1 and Q2; sda changes only in Q0.
REQ-015 States: IDLE, START, DATA, ACK, HOLD, STOP.
REQ-016 ready = 1 only in IDLE and HOLD, and falls the cycle after acceptance.
REQ-017 Acceptance: ready && i2c_en on a posedge; qualifier priority is start > stop > plain write.
REQ-018 IDLE: scl = 1, sda released; start -> START; stop or plain write -> ignored, ready stays 1.
REQ-019 HOLD (bus owned): scl = 0, sda driven 0; start -> START (repeated START); stop -> STOP; plain write -> DATA.
REQ-020 START, 4 quarters:
- sda released, scl high
- sda low, scl high
- sda low, scl low
- then -> DATA.
From HOLD, one extra quarter runs first with scl low and sda released.
REQ-021 tx_data is captured on the START->DATA transition for start commands, and on the cycle after acceptance for plain writes; later tx_data changes have no effect on the byte in flight.
REQ-022 DATA: 8 bits MSB first, bit counter 0-7; after bit 7 -> ACK.
REQ-023 ACK: sda released; sda sampled on the clk where Q2 begins; sample 1 sets ack_err.
REQ-024 End of ACK Q3: tx_done pulses for exactly 1 cycle and the state moves to HOLD. A NACK does not abort the transfer; the upstream block decides the next command.
REQ-025 STOP, 4 quarters:
- sda low, scl low
- sda low, scl high
- sda released, scl high
- hold one quarter, then -> IDLE.
REQ-026 ack_err clears only on acceptance of a start command, or on reset.
REQ-027 Command inputs are ignored while ready = 0; holding i2c_en high across the busy window never causes a double acceptance, because acceptance requires ready = 1.
REQ-028 The quarter counter restarts at 0 on every state entry, so state timing is exact: START = 4*QDIV cycles, byte plus ACK = 36*QDIV cycles.

Reset
REQ-029 Reset values: state IDLE, scl = 1, sda released, ready = 1, tx_done = 0, ack_err = 0, all counters 0.
REQ-030 Reset asserted mid-transfer takes effect immediately (asynchronous), with no STOP generated.

Structure
REQ-031 Package i2c_pkg holds the state enum and quarter-phase constants; QDIV is derived locally from the parameters.
REQ-032 One sub-module, i2c_qtick_gen, generates the quarter tick; it has a clear input driven on state entry.

Verification
REQ-033 start=1, i2c_en=1, tx_data=0xAA, slave ACKs:
- START seen (sda falls while scl=1).
- scl-rising samples 1,0,1,0,1,0,1,0.
- tx_done pulses once, 40*QDIV cycles after acceptance ±2.
- ready=1, scl=0.
REQ-034 From HOLD, plain write tx_data=0x04 changed to 0x00 one cycle after acceptance: bits sent are 0x00; ack_err stays 0.
REQ-035 Slave NACKs a byte: ack_err=1 and stays 1 through STOP; next start command clears it.
REQ-036 From HOLD, start then stop:
- repeated START: sda rises while scl low, then falls while scl high.
- STOP: sda rises while scl high.
- ready returns to 1, with scl=1 and sda='z'.
REQ-037 In IDLE, plain write and stop pulses: no scl/sda activity, ready stays 1.
REQ-038 Reset asserted during DATA bit 3: same cycle scl=1, sda='z', ready=1; a following start runs a full normal transfer.
